// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM defaults and capture state encoding
package pwm_pkg;

   // Clocks per tick; generator and capture must agree on this time base.
   localparam int WAVE_WEIGHT_DEFAULT    = 1024;
   // Width of wave length and pulse width fields, in ticks.
   localparam int WAVE_LEN_WIDTH_DEFAULT = 11;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SYNC     = 2'd1,
      ACTIVE   = 2'd2,
      INACTIVE = 2'd3
   } pwm_state_e;

endpackage

// File: rtl/pwm_tick_gen.sv
// rtl/pwm_tick_gen.sv - free-running weight counter producing one-clock tick pulses
module pwm_tick_gen
   import pwm_pkg::*;
#(
   parameter int WAVE_WEIGHT       = WAVE_WEIGHT_DEFAULT,
   parameter int WAVE_WEIGHT_WIDTH = $clog2(WAVE_WEIGHT + 1)
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam logic [WAVE_WEIGHT_WIDTH-1:0] WEIGHT_MAX = WAVE_WEIGHT_WIDTH'(WAVE_WEIGHT - 1);
   localparam logic [WAVE_WEIGHT_WIDTH-1:0] WEIGHT_ONE = WAVE_WEIGHT_WIDTH'(1);

   logic [WAVE_WEIGHT_WIDTH-1:0] weight_cnt_q, weight_cnt_d;
   logic                         tick_q, tick_d;

   // Count 0..WAVE_WEIGHT-1 and flag the wrap so the tick is registered.
   always_comb begin
      tick_d       = (weight_cnt_q == WEIGHT_MAX);
      weight_cnt_d = tick_d ? '0 : weight_cnt_q + WEIGHT_ONE;
   end

   // Counter and tick flops; the counter ignores enable so all users share one phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         weight_cnt_q <= '0;
         tick_q       <= 1'b0;
      end else begin
         weight_cnt_q <= weight_cnt_d;
         tick_q       <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM decoder measuring wave length and pulse width in ticks
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int WAVE_WEIGHT       = WAVE_WEIGHT_DEFAULT,
   parameter int WAVE_LEN_WIDTH    = WAVE_LEN_WIDTH_DEFAULT,
   parameter int WAVE_WEIGHT_WIDTH = $clog2(WAVE_WEIGHT + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      active_high,
   input  logic                      pwm_in,
   output logic [WAVE_LEN_WIDTH-1:0] wave_length_out,
   output logic [WAVE_LEN_WIDTH-1:0] pulse_width_out,
   output logic                      active_high_out,
   output logic                      valid,
   output logic                      timeout,
   output logic                      locked
);

   localparam logic [WAVE_LEN_WIDTH-1:0] LEN_ONE = WAVE_LEN_WIDTH'(1);
   localparam logic [WAVE_LEN_WIDTH-1:0] LEN_MAX = '1;

   logic tick;

   pwm_tick_gen #(
      .WAVE_WEIGHT       (WAVE_WEIGHT),
      .WAVE_WEIGHT_WIDTH (WAVE_WEIGHT_WIDTH)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   pwm_state_e                state_q, state_d;
   logic                      sync1_q, sync1_d, sync2_q, sync2_d;
   logic                      a_prev_q, a_prev_d;
   logic [WAVE_LEN_WIDTH-1:0] period_cnt_q, period_cnt_d;
   logic [WAVE_LEN_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
   logic [WAVE_LEN_WIDTH-1:0] wave_length_q, wave_length_d;
   logic [WAVE_LEN_WIDTH-1:0] pulse_width_q, pulse_width_d;
   logic                      active_high_q, active_high_d;
   logic                      valid_q, valid_d;
   logic                      timeout_q, timeout_d;
   logic                      locked_q, locked_d;
   logic                      level;
   logic                      act_edge;
   logic                      cnt_sat;

   // Next-state logic: synchronizer, edge detect on ticks, measurement FSM.
   always_comb begin
      sync1_d       = pwm_in;
      sync2_d       = sync1_q;
      level         = sync2_q ^ ~active_high;
      act_edge      = level & ~a_prev_q;
      cnt_sat       = (period_cnt_q == LEN_MAX);
      a_prev_d      = tick ? level : a_prev_q;
      state_d       = state_q;
      period_cnt_d  = period_cnt_q;
      pulse_cnt_d   = pulse_cnt_q;
      wave_length_d = wave_length_q;
      pulse_width_d = pulse_width_q;
      active_high_d = active_high_q;
      valid_d       = 1'b0;
      timeout_d     = 1'b0;
      locked_d      = locked_q;

      if (!enable) begin
         // Disable abandons any measurement silently; results stay visible.
         state_d  = IDLE;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: state_d = SYNC;
            SYNC: begin
               if (tick && act_edge) begin
                  period_cnt_d = LEN_ONE;
                  pulse_cnt_d  = LEN_ONE;
                  state_d      = ACTIVE;
               end
            end
            ACTIVE: begin
               if (tick) begin
                  if (cnt_sat) begin
                     timeout_d = 1'b1;
                     locked_d  = 1'b0;
                     state_d   = SYNC;
                  end else begin
                     period_cnt_d = period_cnt_q + LEN_ONE;
                     if (level) pulse_cnt_d = pulse_cnt_q + LEN_ONE;
                     else       state_d     = INACTIVE;
                  end
               end
            end
            INACTIVE: begin
               if (tick) begin
                  // A completing edge wins over saturation, so a full-scale period still reports.
                  if (act_edge) begin
                     wave_length_d = period_cnt_q;
                     pulse_width_d = pulse_cnt_q;
                     active_high_d = active_high;
                     valid_d       = 1'b1;
                     locked_d      = 1'b1;
                     period_cnt_d  = LEN_ONE;
                     pulse_cnt_d   = LEN_ONE;
                     state_d       = ACTIVE;
                  end else if (cnt_sat) begin
                     timeout_d = 1'b1;
                     locked_d  = 1'b0;
                     state_d   = SYNC;
                  end else begin
                     period_cnt_d = period_cnt_q + LEN_ONE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         a_prev_q      <= 1'b0;
         period_cnt_q  <= '0;
         pulse_cnt_q   <= '0;
         wave_length_q <= '0;
         pulse_width_q <= '0;
         active_high_q <= 1'b0;
         valid_q       <= 1'b0;
         timeout_q     <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         a_prev_q      <= a_prev_d;
         period_cnt_q  <= period_cnt_d;
         pulse_cnt_q   <= pulse_cnt_d;
         wave_length_q <= wave_length_d;
         pulse_width_q <= pulse_width_d;
         active_high_q <= active_high_d;
         valid_q       <= valid_d;
         timeout_q     <= timeout_d;
         locked_q      <= locked_d;
      end
   end

   assign wave_length_out = wave_length_q;
   assign pulse_width_out = pulse_width_q;
   assign active_high_out = active_high_q;
   assign valid           = valid_q;
   assign timeout         = timeout_q;
   assign locked          = locked_q;

endmodule
